// File: rtl/dbus_decoder_if.sv
// Data bus decoder types and the CPU-side bus interface.
// dbus_decoder_pkg holds the one-hot chip-select layout shared by the decoder and its bus.
package dbus_decoder_pkg;

  typedef struct packed {
    logic vga;
    logic irq;
    logic uart;
    logic switches;
    logic display;
    logic keyboard;
    logic vram;
    logic ram;
    logic bios;
  } chip_select_t;

  typedef enum logic [3:0] {
    DEV_BIOS     = 4'd0,
    DEV_RAM      = 4'd1,
    DEV_VRAM     = 4'd2,
    DEV_KEYBOARD = 4'd3,
    DEV_DISPLAY  = 4'd4,
    DEV_SWITCHES = 4'd5,
    DEV_UART     = 4'd6,
    DEV_IRQ      = 4'd7,
    DEV_VGA      = 4'd8
  } device_t;

  localparam int unsigned NUM_DEVICES = 9;

endpackage

interface dbus_decoder_if;
  import dbus_decoder_pkg::*;

  logic [31:0]      addr_i;
  logic             read_enable_i;
  logic [3:0]       write_enable_i;
  logic [8:0][31:0] dev_read_data_i;
  chip_select_t     chip_select_o;
  logic [31:0]      read_data_o;
  logic             read_valid_o;
  logic             bus_error_o;
  logic [31:0]      fault_addr_o;
  logic [7:0]       error_count_o;

  modport master (
    output addr_i, read_enable_i, write_enable_i, dev_read_data_i,
    input  chip_select_o, read_data_o, read_valid_o, bus_error_o,
           fault_addr_o, error_count_o
  );

  modport slave (
    input  addr_i, read_enable_i, write_enable_i, dev_read_data_i,
    output chip_select_o, read_data_o, read_valid_o, bus_error_o,
           fault_addr_o, error_count_o
  );

endinterface

// File: rtl/dbus_decoder.sv
// Data bus address decoder: one-hot chip selects, 1-cycle read steering, unmapped-access reporting.
// Define DBUS_FAULT_CAPTURE_EN to keep the faulting address and a saturating error count.
module dbus_decoder
  import dbus_decoder_pkg::*;
(
  input logic      clk_i,
  input logic      reset_ni,
  dbus_decoder_if.slave bus
);

  logic         access;
  logic         mapped;
  device_t      dev_sel;
  logic [8:0]   cs_vec;

  device_t      steer_q;
  logic         read_pending_q;
  logic         read_unmapped_q;
  logic         bus_error_q;
  logic [31:0]  read_hold_q;
  logic [31:0]  read_steered;

  assign access = bus.read_enable_i | (|bus.write_enable_i);

  // Region from the top nibble; the I/O region is subdecoded on addr[7:4] only.
  always_comb begin
    mapped  = 1'b0;
    dev_sel = DEV_BIOS;
    case (bus.addr_i[31:28])
      4'h0: begin mapped = 1'b1; dev_sel = DEV_BIOS; end
      4'h1: begin mapped = 1'b1; dev_sel = DEV_RAM;  end
      4'h2: begin mapped = 1'b1; dev_sel = DEV_VRAM; end
      4'hF: begin
        case (bus.addr_i[7:4])
          4'h0: begin mapped = 1'b1; dev_sel = DEV_KEYBOARD; end
          4'h1: begin mapped = 1'b1; dev_sel = DEV_DISPLAY;  end
          4'h2: begin mapped = 1'b1; dev_sel = DEV_SWITCHES; end
          4'h3: begin mapped = 1'b1; dev_sel = DEV_UART;     end
          4'h4: begin mapped = 1'b1; dev_sel = DEV_IRQ;      end
          4'h5: begin mapped = 1'b1; dev_sel = DEV_VGA;      end
          default: begin mapped = 1'b0; dev_sel = DEV_BIOS; end
        endcase
      end
      default: begin mapped = 1'b0; dev_sel = DEV_BIOS; end
    endcase
  end

  always_comb begin
    cs_vec = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      cs_vec[i] = access & mapped & (dev_sel == 4'(i));
    end
  end

  assign bus.chip_select_o = chip_select_t'(cs_vec);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      steer_q         <= DEV_BIOS;
      read_pending_q  <= 1'b0;
      read_unmapped_q <= 1'b0;
      bus_error_q     <= 1'b0;
      read_hold_q     <= '0;
    end else begin
      read_pending_q  <= bus.read_enable_i;
      read_unmapped_q <= bus.read_enable_i & ~mapped;
      bus_error_q     <= access & ~mapped;
      if (bus.read_enable_i && mapped) begin
        steer_q <= dev_sel;
      end
      if (read_pending_q) begin
        read_hold_q <= read_steered;
      end
    end
  end

  // Device data arrives the cycle after its select, so the mux is combinational on the registered index.
  always_comb begin
    read_steered = '0;
    if (!read_unmapped_q) begin
      case (steer_q)
        DEV_BIOS:     read_steered = bus.dev_read_data_i[0];
        DEV_RAM:      read_steered = bus.dev_read_data_i[1];
        DEV_VRAM:     read_steered = bus.dev_read_data_i[2];
        DEV_KEYBOARD: read_steered = bus.dev_read_data_i[3];
        DEV_DISPLAY:  read_steered = bus.dev_read_data_i[4];
        DEV_SWITCHES: read_steered = bus.dev_read_data_i[5];
        DEV_UART:     read_steered = bus.dev_read_data_i[6];
        DEV_IRQ:      read_steered = bus.dev_read_data_i[7];
        DEV_VGA:      read_steered = bus.dev_read_data_i[8];
        default:      read_steered = '0;
      endcase
    end
  end

  assign bus.read_data_o  = read_pending_q ? read_steered : read_hold_q;
  assign bus.read_valid_o = read_pending_q;
  assign bus.bus_error_o  = bus_error_q;

`ifdef DBUS_FAULT_CAPTURE_EN
  logic [31:0] fault_addr_q;
  logic [7:0]  error_count_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fault_addr_q  <= '0;
      error_count_q <= '0;
    end else if (access && !mapped) begin
      fault_addr_q <= bus.addr_i;
      if (error_count_q != 8'hFF) begin
        error_count_q <= error_count_q + 8'd1;
      end
    end
  end

  assign bus.fault_addr_o  = fault_addr_q;
  assign bus.error_count_o = error_count_q;
`else
  logic unused_addr_bits;

  assign unused_addr_bits  = ^{bus.addr_i[27:8], bus.addr_i[3:0]};
  assign bus.fault_addr_o  = '0;
  assign bus.error_count_o = '0;
`endif

endmodule

// File: tb/tb_dbus_decoder.sv
// Self-checking bench for dbus_decoder: directed scenarios plus randomized traffic against a
// transaction-level reference model; fault capture expectations follow DBUS_FAULT_CAPTURE_EN.
module tb_dbus_decoder;

  logic clk = 1'b0;
  logic reset_ni;

  dbus_decoder_if bus ();

  dbus_decoder dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the last clock edge captured, in transaction terms.
  bit          m_valid;
  int          m_dev;
  logic [31:0] m_hold;
  bit          m_err;
  logic [31:0] m_fault;
  int          m_count;

  function automatic int device_of(input logic [31:0] a);
    int top;
    int sub;
    top = int'(a >> 28);
    sub = int'((a >> 4) & 32'hF);
    if (top <= 2) return top;
    if (top == 15 && sub <= 5) return 3 + sub;
    return -1;
  endfunction

  function automatic logic [8:0] exp_cs(input logic [31:0] a, input logic re, input logic [3:0] we);
    logic [8:0] one;
    int d;
    one = 9'd1;
    d = device_of(a);
    if ((re || we != 4'h0) && d >= 0) return one << d;
    return 9'd0;
  endfunction

  function automatic logic [31:0] exp_read_data();
    if (!m_valid) return m_hold;
    if (m_dev < 0) return 32'h0;
    return bus.dev_read_data_i[m_dev];
  endfunction

  function automatic logic [31:0] exp_fault_addr();
`ifdef DBUS_FAULT_CAPTURE_EN
    return m_fault;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [7:0] exp_error_count();
`ifdef DBUS_FAULT_CAPTURE_EN
    return 8'(m_count);
`else
    return 8'h0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_dev   = 0;
    m_hold  = 32'h0;
    m_err   = 0;
    m_fault = 32'h0;
    m_count = 0;
  endtask

  task automatic model_update();
    int d;
    bit acc;
    if (!reset_ni) return;
    if (m_valid) m_hold = exp_read_data();
    d = device_of(bus.addr_i);
    acc = bus.read_enable_i || (bus.write_enable_i != 4'h0);
    m_valid = bus.read_enable_i;
    if (bus.read_enable_i) m_dev = d;
    m_err = acc && (d < 0);
    if (m_err) begin
      m_fault = bus.addr_i;
      m_count = (m_count < 255) ? m_count + 1 : 255;
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic re, input logic [3:0] we);
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 9; i++) bus.dev_read_data_i[i] = $urandom;
    bus.addr_i         = a;
    bus.read_enable_i  = re;
    bus.write_enable_i = we;
  endtask

  task automatic test_reset();
    model_reset();
    reset_ni = 1'b0;
    bus.addr_i = 32'h1000_0000;
    bus.read_enable_i = 1'b1;
    bus.write_enable_i = 4'h0;
    for (int i = 0; i < 9; i++) bus.dev_read_data_i[i] = 32'h0;
    #2;
    checks++; if (bus.read_data_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_read_data got %h want %h", bus.read_data_o, 32'h0); end
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_valid got %b want 0", bus.read_valid_o); end
    checks++; if (bus.bus_error_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_error got %b want 0", bus.bus_error_o); end
    checks++; if (bus.fault_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_fault_addr got %h want 0", bus.fault_addr_o); end
    checks++; if (bus.error_count_o !== 8'h0) begin errors++; $display("[TB] FAIL reset_error_count got %h want 0", bus.error_count_o); end
    checks++; if (bus.chip_select_o !== 9'h002) begin errors++; $display("[TB] FAIL reset_comb_cs got %h want %h", bus.chip_select_o, 9'h002); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_held_valid got %b want 0", bus.read_valid_o); end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    reset_ni = 1'b1;
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_valid got %b want 0", bus.read_valid_o); end
  endtask

  task automatic test_unmapped_write();
    apply_stimulus(32'h5000_0000, 1'b0, 4'hF);
    @(negedge clk);
    checks++; if (bus.chip_select_o !== 9'h000) begin errors++; $display("[TB] FAIL unmapped_cs got %h want 000", bus.chip_select_o); end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    @(negedge clk);
    checks++; if (bus.bus_error_o !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_bus_error got %b want 1", bus.bus_error_o); end
`ifdef DBUS_FAULT_CAPTURE_EN
    checks++; if (bus.fault_addr_o !== 32'h5000_0000) begin errors++; $display("[TB] FAIL unmapped_fault_addr got %h want 50000000", bus.fault_addr_o); end
    checks++; if (bus.error_count_o !== 8'd1) begin errors++; $display("[TB] FAIL unmapped_error_count got %0d want 1", bus.error_count_o); end
`else
    checks++; if (bus.fault_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_fault_addr got %h want 0", bus.fault_addr_o); end
    checks++; if (bus.error_count_o !== 8'd0) begin errors++; $display("[TB] FAIL unmapped_error_count got %0d want 0", bus.error_count_o); end
`endif
    apply_stimulus(32'h0, 1'b0, 4'h0);
    @(negedge clk);
    checks++; if (bus.bus_error_o !== 1'b0) begin errors++; $display("[TB] FAIL unmapped_pulse_end got %b want 0", bus.bus_error_o); end
  endtask

  task automatic test_ram_read();
    apply_stimulus(32'h1000_0040, 1'b1, 4'h0);
    @(negedge clk);
    checks++; if (bus.chip_select_o !== 9'h002) begin errors++; $display("[TB] FAIL ram_cs got %h want 002", bus.chip_select_o); end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    bus.dev_read_data_i[1] = 32'h1234_5678;
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ram_valid got %b want 1", bus.read_valid_o); end
    checks++; if (bus.read_data_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ram_data got %h want 12345678", bus.read_data_o); end
  endtask

  task automatic test_back_to_back();
    apply_stimulus(32'h0000_0000, 1'b1, 4'h0);
    apply_stimulus(32'hF000_0030, 1'b1, 4'h0);
    bus.dev_read_data_i[0] = 32'hAAAA_AAAA;
    @(negedge clk);
    checks++; if (bus.chip_select_o !== 9'h040) begin errors++; $display("[TB] FAIL b2b_uart_cs got %h want 040", bus.chip_select_o); end
    checks++; if (bus.read_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid0 got %b want 1", bus.read_valid_o); end
    checks++; if (bus.read_data_o !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL b2b_bios_data got %h want aaaaaaaa", bus.read_data_o); end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    bus.dev_read_data_i[6] = 32'h0000_0055;
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid1 got %b want 1", bus.read_valid_o); end
    checks++; if (bus.read_data_o !== 32'h0000_0055) begin errors++; $display("[TB] FAIL b2b_uart_data got %h want 00000055", bus.read_data_o); end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL hold_valid got %b want 0", bus.read_valid_o); end
    checks++; if (bus.read_data_o !== 32'h0000_0055) begin errors++; $display("[TB] FAIL hold_data got %h want 00000055", bus.read_data_o); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(32'hF000_0070, 1'b1, 4'h0);
      @(negedge clk);
      if (n > 0) begin
        checks++; if (bus.read_data_o !== 32'h0) begin errors++; $display("[TB] FAIL sat_data n=%0d got %h want 0", n, bus.read_data_o); end
        checks++; if (bus.read_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL sat_valid n=%0d got %b want 1", n, bus.read_valid_o); end
        checks++; if (bus.bus_error_o !== 1'b1) begin errors++; $display("[TB] FAIL sat_bus_error n=%0d got %b want 1", n, bus.bus_error_o); end
        checks++; if (bus.error_count_o !== exp_error_count()) begin errors++; $display("[TB] FAIL sat_count n=%0d got %0d want %0d", n, bus.error_count_o, exp_error_count()); end
      end
    end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    @(negedge clk);
    checks++; if (bus.bus_error_o !== 1'b1) begin errors++; $display("[TB] FAIL sat_last_error got %b want 1", bus.bus_error_o); end
`ifdef DBUS_FAULT_CAPTURE_EN
    checks++; if (bus.error_count_o !== 8'hFF) begin errors++; $display("[TB] FAIL sat_final_count got %h want ff", bus.error_count_o); end
`else
    checks++; if (bus.error_count_o !== 8'h00) begin errors++; $display("[TB] FAIL sat_final_count got %h want 00", bus.error_count_o); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        re;
    logic [3:0]  we;
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: a[31:28] = 4'h0;
        1: a[31:28] = 4'h1;
        2: a[31:28] = 4'h2;
        3: a[31:28] = 4'hF;
        default: ;
      endcase
      re = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      apply_stimulus(a, re, we);
      @(negedge clk);
      checks++; if (bus.chip_select_o !== exp_cs(a, re, we)) begin errors++; $display("[TB] FAIL rand_cs n=%0d got %h want %h", n, bus.chip_select_o, exp_cs(a, re, we)); end
      checks++; if (bus.read_valid_o !== m_valid) begin errors++; $display("[TB] FAIL rand_valid n=%0d got %b want %b", n, bus.read_valid_o, m_valid); end
      checks++; if (bus.read_data_o !== exp_read_data()) begin errors++; $display("[TB] FAIL rand_data n=%0d got %h want %h", n, bus.read_data_o, exp_read_data()); end
      checks++; if (bus.bus_error_o !== m_err) begin errors++; $display("[TB] FAIL rand_bus_error n=%0d got %b want %b", n, bus.bus_error_o, m_err); end
      checks++; if (bus.fault_addr_o !== exp_fault_addr()) begin errors++; $display("[TB] FAIL rand_fault n=%0d got %h want %h", n, bus.fault_addr_o, exp_fault_addr()); end
      checks++; if (bus.error_count_o !== exp_error_count()) begin errors++; $display("[TB] FAIL rand_count n=%0d got %0d want %0d", n, bus.error_count_o, exp_error_count()); end
    end
  endtask

  task automatic test_reset_mid_read();
    apply_stimulus(32'h2000_0000, 1'b1, 4'h0);
    @(posedge clk);
    model_update();
    #1;
    reset_ni = 1'b0;
    model_reset();
    bus.addr_i = 32'h0;
    bus.read_enable_i = 1'b0;
    bus.write_enable_i = 4'h0;
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", bus.read_valid_o); end
    apply_stimulus(32'h0, 1'b0, 4'h0);
    reset_ni = 1'b1;
    @(negedge clk);
    checks++; if (bus.read_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_release_valid got %b want 0", bus.read_valid_o); end
    checks++; if (bus.read_data_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_data got %h want 0", bus.read_data_o); end
    checks++; if (bus.bus_error_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_bus_error got %b want 0", bus.bus_error_o); end
    checks++; if (bus.fault_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_fault got %h want 0", bus.fault_addr_o); end
    checks++; if (bus.error_count_o !== 8'h0) begin errors++; $display("[TB] FAIL midrst_count got %h want 0", bus.error_count_o); end
  endtask

  initial begin
    test_reset();
    test_unmapped_write();
    test_ram_read();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_decoder.md
DBUS_DECODER -- requirements
Module: dbus_decoder

Interface
REQ-001 clk_i  in  1  system clock; all state on rising edge.
REQ-002 reset_ni  in  1  asynchronous, active-low reset.
REQ-003 addr_i  in  32  data bus byte address.
REQ-004 read_enable_i  in  1  read request this cycle.
REQ-005 write_enable_i  in  4  byte write mask; nonzero = write request.
REQ-006 dev_read_data_i  in  9x32  per-device read data, index 0..8 = bios, ram, vram, keyboard, display, switches, uart, irq, vga; valid one cycle after that device's select.
REQ-007 chip_select_o  out  chip_select_t  one-hot device select, combinational from addr_i.
REQ-008 read_data_o  out  32  steered read data.
REQ-009 read_valid_o  out  1  read data valid pulse.
REQ-010 bus_error_o  out  1  unmapped-access pulse.
REQ-011 fault_addr_o  out  32  address of most recent unmapped access.
REQ-012 error_count_o  out  8  saturating unmapped-access count.

Function
REQ-013 Access = read_enable_i OR |write_enable_i; chip_select_o SHALL be all-zero when no access.
REQ-014 Map by addr_i[31:28]: 0x0 bios, 0x1 ram, 0x2 vram, 0xF I/O; all other values unmapped.
REQ-015 I/O subdecode by addr_i[7:4]: 0 keyboard, 1 display, 2 switches, 3 uart, 4 irq, 5 vga; 6..F unmapped; addr_i[27:8] ignored.
REQ-016 chip_select_o SHALL have at most one bit set in every cycle.
REQ-017 On a read to a mapped device, the device index SHALL be registered; next cycle read_data_o = dev_read_data_i[index] and read_valid_o = 1 (latency exactly 1 cycle).
REQ-018 On a read to an unmapped address, next cycle read_data_o = 0x0000_0000 and read_valid_o = 1.
REQ-019 Without a read in the previous cycle, read_valid_o = 0 and read_data_o SHALL hold its last value.
REQ-020 Back-to-back reads to different devices SHALL each return their own device data in consecutive cycles with no bubble.
REQ-021 Simultaneous read and write: one chip select; read steering as REQ-017; write handled by the device.
REQ-022 Any access (read or write) to an unmapped address SHALL assert bus_error_o for exactly one cycle, in the following cycle.
REQ-023 Each unmapped access SHALL increment error_count_o by 1, saturating at 0xFF; fault_addr_o SHALL capture addr_i of that access.
REQ-024 Consecutive unmapped accesses SHALL each pulse bus_error_o, giving a continuous high level, and each SHALL be counted.

Reset
REQ-025 While reset_ni = 0: read_data_o = 0, read_valid_o = 0, bus_error_o = 0, fault_addr_o = 0, error_count_o = 0, steering register = bios.
REQ-026 chip_select_o SHALL remain combinational during reset.
REQ-027 Reset asserted mid-read SHALL discard the pending read; read_valid_o SHALL be 0 in the first cycle after reset release.

Configuration
REQ-028 Macro DBUS_FAULT_CAPTURE_EN: defined -> fault_addr_o and error_count_o SHALL behave per REQ-023.
REQ-029 DBUS_FAULT_CAPTURE_EN undefined -> fault_addr_o and error_count_o SHALL be constant 0 with no registers; bus_error_o and all other behaviour unchanged.

Verification
REQ-030 Read 0x1000_0040, ram data 0x1234_5678 -> chip_select_o.ram = 1 same cycle; next cycle read_data_o = 0x1234_5678, read_valid_o = 1.
REQ-031 Reads 0x0000_0000 then 0xF000_0030 back-to-back, bios = 0xAAAA_AAAA, uart = 0x0000_0055 -> read_data_o = 0xAAAA_AAAA then 0x0000_0055 in consecutive cycles.
REQ-032 Write mask 0xF to 0x5000_0000 -> chip_select_o = 0; next cycle bus_error_o = 1 for one cycle; fault_addr_o = 0x5000_0000; error_count_o = 1.
REQ-033 300 consecutive reads of 0xF000_0070 -> read_data_o = 0 each cycle, bus_error_o high throughout, error_count_o saturates at 0xFF.
REQ-034 Read 0x2000_0000, then reset_ni low for 1 cycle before the data cycle -> read_valid_o = 0, all registered outputs 0 after release.
REQ-035 Build without DBUS_FAULT_CAPTURE_EN, repeat REQ-032 -> bus_error_o pulses; fault_addr_o = 0, error_count_o = 0.
